// File: rtl/numbers_pkg.sv
// Shared BCD types, limits and debounce FSM states for the number display blocks.
package numbers_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX_DIGIT = 4'd9;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } debounce_state_t;

    // Saturate a nibble into the legal BCD range 0..9
    function automatic bcd_digit_t bcd_clamp(input bcd_digit_t d);
        return (d > BCD_MAX_DIGIT) ? BCD_MAX_DIGIT : d;
    endfunction

endpackage

// File: rtl/bcd_event_counter_if.sv
// Button, control and display bundle between the counter and its user.
interface bcd_event_counter_if #(
    parameter int unsigned DIGITS = 3
);
    logic                  btn_n;
    logic                  dir_up;
    logic                  load;
    logic [4*DIGITS-1:0]   load_value;
    logic [4*DIGITS-1:0]   bcd;
    logic                  press;
    logic                  overflow;
    logic                  at_max;
    logic                  at_min;

    modport master (
        output btn_n, dir_up, load, load_value,
        input  bcd, press, overflow, at_max, at_min
    );

    modport slave (
        input  btn_n, dir_up, load, load_value,
        output bcd, press, overflow, at_max, at_min
    );
endinterface

// File: rtl/bcd_event_counter_debouncer.sv
// Two-flop synchroniser plus level-qualifying FSM; emits one press pulse per
// qualified button press, no auto-repeat.
module button_debouncer
    import numbers_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 500000
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic btn_n,
    output logic press
);
    localparam int unsigned      CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    debounce_state_t  r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_press;

    debounce_state_t  w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_press_nxt;

    // Synchroniser resets to the released level
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
        end else begin
            r_sync1 <= btn_n;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_press <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_press <= w_press_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (!r_sync2) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = PRESS_WAIT;
                end
            end
            PRESS_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            HELD: begin
                if (r_sync2) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign press = r_press;

endmodule

// File: rtl/bcd_event_counter.sv
// Debounced press counter in packed BCD with up/down, wrap or saturate limits
// and a clamped synchronous load.
module bcd_event_counter
    import numbers_pkg::*;
#(
    parameter int unsigned DIGITS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter bit          SATURATE        = 1'b0
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    bcd_event_counter_if.slave bus
);
    localparam int unsigned BCD_W = 4 * DIGITS;

    logic [BCD_W-1:0] r_bcd;
    logic             r_overflow;

    logic             w_press;
    logic [BCD_W-1:0] w_inc;
    logic [BCD_W-1:0] w_dec;
    logic [BCD_W-1:0] w_load_clamped;
    logic             w_carry;
    logic             w_borrow;
    logic             w_all_nines;
    logic             w_all_zero;

    button_debouncer #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debouncer (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .btn_n   (bus.btn_n),
        .press   (w_press)
    );

    // Ripple carry/borrow across digits; all-nines +1 naturally yields zero
    always_comb begin
        w_inc    = r_bcd;
        w_dec    = r_bcd;
        w_carry  = 1'b1;
        w_borrow = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (w_carry) begin
                if (r_bcd[4*i +: 4] == BCD_MAX_DIGIT) begin
                    w_inc[4*i +: 4] = 4'd0;
                end else begin
                    w_inc[4*i +: 4] = r_bcd[4*i +: 4] + 4'd1;
                    w_carry         = 1'b0;
                end
            end
            if (w_borrow) begin
                if (r_bcd[4*i +: 4] == 4'd0) begin
                    w_dec[4*i +: 4] = BCD_MAX_DIGIT;
                end else begin
                    w_dec[4*i +: 4] = r_bcd[4*i +: 4] - 4'd1;
                    w_borrow        = 1'b0;
                end
            end
        end
    end

    always_comb begin
        w_load_clamped = '0;
        for (int i = 0; i < int'(DIGITS); i++) begin
            w_load_clamped[4*i +: 4] = bcd_clamp(bus.load_value[4*i +: 4]);
        end
    end

    assign w_all_nines = (r_bcd == {DIGITS{BCD_MAX_DIGIT}});
    assign w_all_zero  = (r_bcd == '0);

    // Load wins over a press in the same cycle and suppresses overflow
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_bcd      <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= 1'b0;
            if (bus.load) begin
                r_bcd <= w_load_clamped;
            end else if (w_press) begin
                if (bus.dir_up) begin
                    if (w_all_nines) begin
                        r_overflow <= 1'b1;
                        if (!SATURATE) r_bcd <= w_inc;
                    end else begin
                        r_bcd <= w_inc;
                    end
                end else begin
                    if (w_all_zero) begin
                        r_overflow <= 1'b1;
                        if (!SATURATE) r_bcd <= w_dec;
                    end else begin
                        r_bcd <= w_dec;
                    end
                end
            end
        end
    end

    assign bus.bcd      = r_bcd;
    assign bus.press    = w_press;
    assign bus.overflow = r_overflow;
    assign bus.at_max   = w_all_nines;
    assign bus.at_min   = w_all_zero;

endmodule
